// File: rtl/wrr_packet_arbiter.sv
// Weighted round-robin packet arbiter.
// Several master streams share one valid/ready slave stream. A granted master
// keeps the slave until its last beat is accepted. Each port may send up to
// its weight in back-to-back packets before priority moves on to the next port.
module wrr_packet_arbiter #(
  parameter int PORTS_N  = 3,
  parameter int DATA_W   = 32,
  parameter int WEIGHT_W = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [PORTS_N*WEIGHT_W-1:0]  i_weight,
  input  logic [PORTS_N-1:0]           i_master_valid,
  input  logic [PORTS_N*DATA_W-1:0]    i_master_data,
  input  logic [PORTS_N-1:0]           i_master_last,
  output logic [PORTS_N-1:0]           o_master_ready,
  output logic                         o_slave_valid,
  output logic [DATA_W-1:0]            o_slave_data,
  output logic                         o_slave_last,
  input  logic                         i_slave_ready,
  output logic [PORTS_N-1:0]           o_grant_oh,
  output logic                         o_busy
);

  localparam int PTR_W = (PORTS_N > 1) ? $clog2(PORTS_N) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [PORTS_N-1:0]  grant_oh_q, grant_oh_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [WEIGHT_W-1:0] cnt_q, cnt_d;

  logic [PTR_W-1:0]    sel_idx;
  logic [PTR_W-1:0]    grant_idx;
  logic [PTR_W-1:0]    grant_next_idx;
  logic [WEIGHT_W-1:0] sel_weight;
  logic [WEIGHT_W-1:0] sel_quantum;
  logic                any_valid;
  logic                fire;

  // Find the first requesting port starting at the priority pointer and wrapping around.
  always_comb begin
    sel_idx = ptr_q;
    for (int k = PORTS_N - 1; k >= 0; k--) begin
      if (i_master_valid[PTR_W'((int'(ptr_q) + k) % PORTS_N)]) begin
        sel_idx = PTR_W'((int'(ptr_q) + k) % PORTS_N);
      end
    end
  end

  // Quantum the selected port would load; a weight of zero counts as one packet.
  always_comb begin
    sel_weight = '0;
    for (int p = 0; p < PORTS_N; p++) begin
      if (sel_idx == PTR_W'(p)) begin
        sel_weight = i_weight[p*WEIGHT_W +: WEIGHT_W];
      end
    end
    sel_quantum = (sel_weight == '0) ? WEIGHT_W'(1) : sel_weight;
  end

  // Route the granted master onto the slave; everything reads zero while no grant is held.
  always_comb begin
    grant_idx    = '0;
    o_slave_data = '0;
    for (int p = 0; p < PORTS_N; p++) begin
      if (grant_oh_q[p]) begin
        grant_idx    = PTR_W'(p);
        o_slave_data = i_master_data[p*DATA_W +: DATA_W];
      end
    end
    grant_next_idx = (grant_idx == PTR_W'(PORTS_N - 1)) ? '0 : grant_idx + PTR_W'(1);
  end

  assign any_valid      = |i_master_valid;
  assign o_slave_valid  = (state_q == LOCKED) && |(i_master_valid & grant_oh_q);
  assign o_slave_last   = (state_q == LOCKED) && |(i_master_last & grant_oh_q);
  assign o_master_ready = (state_q == LOCKED) ? (grant_oh_q & {PORTS_N{i_slave_ready}}) : '0;
  assign fire           = o_slave_valid & i_slave_ready;
  assign o_grant_oh     = grant_oh_q;
  assign o_busy         = (state_q == LOCKED);

  // Arbitrate in IDLE, then hold the grant until the packet's last beat is accepted.
  always_comb begin
    state_d    = state_q;
    grant_oh_d = grant_oh_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d    = LOCKED;
          grant_oh_d = PORTS_N'(1) << sel_idx;
          if ((sel_idx != ptr_q) || (cnt_q == '0)) begin
            ptr_d = sel_idx;
            cnt_d = sel_quantum;
          end
        end
      end
      LOCKED: begin
        if (fire && o_slave_last) begin
          state_d    = IDLE;
          grant_oh_d = '0;
          cnt_d      = cnt_q - WEIGHT_W'(1);
          if (cnt_q == WEIGHT_W'(1)) begin
            ptr_d = grant_next_idx;
          end
        end
      end
    endcase
  end

  // State registers; reset also abandons any packet in flight.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      grant_oh_q <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_oh_q <= grant_oh_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
